// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Groups the decode, EX and MEM hazard inputs and the pipeline control
//   outputs of the hazard controller.
//   master : pipeline side, drives the i_* fields and observes the o_* fields
//   slave  : hazard controller, reads the i_* fields and drives the o_* fields
//   i_ID_*            decode-stage instruction info (valid, sources, dest, kind)
//   i_EX_branch_taken redirect from EX
//   i_MEM_busy        data memory wait
//   o_* stall/flush   pipeline control strobes
//   o_fwd_sel_a/b     operand source for the instruction in EX
//   o_state           controller state (00 RUN, 01 FLUSH, 10 FREEZE)
//   o_perf_stalls     saturating count of IF stall cycles
interface hazard_ctrl_if #(
  parameter int REG_FILE_ADDR = 5
);
  logic                     i_ID_valid;
  logic [REG_FILE_ADDR-1:0] i_ID_rs1;
  logic [REG_FILE_ADDR-1:0] i_ID_rs2;
  logic                     i_ID_rs1_used;
  logic                     i_ID_rs2_used;
  logic [REG_FILE_ADDR-1:0] i_ID_rd;
  logic                     i_ID_wb_en;
  logic                     i_ID_is_load;
  logic                     i_EX_branch_taken;
  logic                     i_MEM_busy;
  logic                     o_IF_stall;
  logic                     o_ID_stall;
  logic                     o_ID_flush;
  logic                     o_EX_bubble;
  logic                     o_pipe_freeze;
  logic [1:0]               o_fwd_sel_a;
  logic [1:0]               o_fwd_sel_b;
  logic [1:0]               o_state;
  logic [15:0]              o_perf_stalls;

  modport master (
    output i_ID_valid, i_ID_rs1, i_ID_rs2, i_ID_rs1_used, i_ID_rs2_used,
           i_ID_rd, i_ID_wb_en, i_ID_is_load, i_EX_branch_taken, i_MEM_busy,
    input  o_IF_stall, o_ID_stall, o_ID_flush, o_EX_bubble, o_pipe_freeze,
           o_fwd_sel_a, o_fwd_sel_b, o_state, o_perf_stalls
  );

  modport slave (
    input  i_ID_valid, i_ID_rs1, i_ID_rs2, i_ID_rs1_used, i_ID_rs2_used,
           i_ID_rd, i_ID_wb_en, i_ID_is_load, i_EX_branch_taken, i_MEM_busy,
    output o_IF_stall, o_ID_stall, o_ID_flush, o_EX_bubble, o_pipe_freeze,
           o_fwd_sel_a, o_fwd_sel_b, o_state, o_perf_stalls
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard detection and forwarding control for a 5-stage in-order pipeline.
//   Tracks the destination of the instructions in EX, MEM, WB and the retired
//   slot, detects load-use hazards, squashes the front end after a taken
//   branch, freezes the back end on a data memory wait and registers the
//   forwarding selects for the instruction entering EX.
//   Ports:
//     i_clk      clock
//     i_reset_n  asynchronous active-low reset
//     bus        hazard_ctrl_if.slave (decode info, branch/busy in, controls out)
module hazard_ctrl #(
  parameter int REG_FILE_DEPTH = 32,
  parameter int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH),
  parameter int FLUSH_CYCLES   = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_FREEZE = 2'b10
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic [REG_FILE_ADDR-1:0] rd;
    logic                     wb_en;
    logic                     is_load;
  } entry_t;

  localparam int EX_I  = 0;
  localparam int MEM_I = 1;
  localparam int WB_I  = 2;
  localparam int RET_I = 3;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t      state;
  state_t      saved_state;
  state_t      eff_state;
  logic [2:0]  flush_cnt;
  entry_t      trk [4];
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic [1:0]  sel_a_next;
  logic [1:0]  sel_b_next;
  logic [15:0] perf_stalls;
  logic        if_stall;
  logic        id_stall;
  logic        id_flush;
  logic        ex_bubble;
  logic        pipe_freeze;
  logic        load_use;
  logic        insert;
  entry_t      ex_next;

  function automatic logic src_match(input entry_t e,
                                     input logic [REG_FILE_ADDR-1:0] rs,
                                     input logic used);
    return e.valid && e.wb_en && (e.rd == rs) && (rs != '0) && used;
  endfunction

  // While frozen, the combinational outputs behave as the state we froze from,
  // so leaving FREEZE takes effect in the same cycle busy drops.
  assign eff_state = (state == ST_FREEZE) ? saved_state : state;

  assign load_use = bus.i_ID_valid && trk[EX_I].is_load &&
                    (src_match(trk[EX_I], bus.i_ID_rs1, bus.i_ID_rs1_used) ||
                     src_match(trk[EX_I], bus.i_ID_rs2, bus.i_ID_rs2_used));

  // Priority: memory freeze, then flush, then load-use stall, then advance.
  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    ex_bubble   = 1'b0;
    pipe_freeze = 1'b0;
    insert      = 1'b0;
    if (i_reset_n) begin
      if (bus.i_MEM_busy) begin
        pipe_freeze = 1'b1;
        if_stall    = 1'b1;
        id_stall    = 1'b1;
      end else if (eff_state == ST_FLUSH || bus.i_EX_branch_taken) begin
        id_flush  = 1'b1;
        ex_bubble = 1'b1;
      end else if (load_use) begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_bubble = 1'b1;
      end else begin
        insert = bus.i_ID_valid;
      end
    end
    ex_next = '0;
    if (insert) begin
      ex_next.valid   = 1'b1;
      ex_next.rd      = bus.i_ID_rd;
      ex_next.wb_en   = bus.i_ID_wb_en;
      ex_next.is_load = bus.i_ID_is_load;
    end
  end

  // The current EX occupant will sit in MEM when the decode instruction
  // reaches EX, so it is the youngest producer and is searched first.
  always_comb begin
    sel_a_next = 2'b00;
    sel_b_next = 2'b00;
    if (src_match(trk[EX_I], bus.i_ID_rs1, bus.i_ID_rs1_used))       sel_a_next = 2'b01;
    else if (src_match(trk[MEM_I], bus.i_ID_rs1, bus.i_ID_rs1_used)) sel_a_next = 2'b10;
    else if (src_match(trk[WB_I], bus.i_ID_rs1, bus.i_ID_rs1_used))  sel_a_next = 2'b11;
    if (src_match(trk[EX_I], bus.i_ID_rs2, bus.i_ID_rs2_used))       sel_b_next = 2'b01;
    else if (src_match(trk[MEM_I], bus.i_ID_rs2, bus.i_ID_rs2_used)) sel_b_next = 2'b10;
    else if (src_match(trk[WB_I], bus.i_ID_rs2, bus.i_ID_rs2_used))  sel_b_next = 2'b11;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_RUN;
      saved_state <= ST_RUN;
      flush_cnt   <= '0;
      for (int i = 0; i < 4; i++) trk[i] <= '0;
      sel_a       <= 2'b00;
      sel_b       <= 2'b00;
      perf_stalls <= '0;
    end else begin
      if (if_stall && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
      if (bus.i_MEM_busy) begin
        // Tracker, selects and flush counter hold; only remember where to resume.
        state <= ST_FREEZE;
        if (state != ST_FREEZE) saved_state <= state;
      end else begin
        trk[RET_I] <= trk[WB_I];
        trk[WB_I]  <= trk[MEM_I];
        trk[MEM_I] <= trk[EX_I];
        trk[EX_I]  <= ex_next;
        sel_a      <= insert ? sel_a_next : 2'b00;
        sel_b      <= insert ? sel_b_next : 2'b00;
        if (eff_state == ST_FLUSH) begin
          flush_cnt <= (flush_cnt <= 3'd1) ? 3'd0 : flush_cnt - 3'd1;
          state     <= (flush_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (bus.i_EX_branch_taken && FLUSH_INIT != 3'd0) begin
          flush_cnt <= FLUSH_INIT;
          state     <= ST_FLUSH;
        end else begin
          state <= ST_RUN;
        end
      end
    end
  end

  assign bus.o_IF_stall    = if_stall;
  assign bus.o_ID_stall    = id_stall;
  assign bus.o_ID_flush    = id_flush;
  assign bus.o_EX_bubble   = ex_bubble;
  assign bus.o_pipe_freeze = pipe_freeze;
  assign bus.o_fwd_sel_a   = sel_a;
  assign bus.o_fwd_sel_b   = sel_b;
  assign bus.o_state       = state;
  assign bus.o_perf_stalls = perf_stalls;

endmodule
